hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the integer core. It generalises the core's fixed two-slot branch squash and stall-free register forwarding into one block. The block has configurable pipeline depth, load-result stage and flush depth, and it adds load-use stall generation. It sits between decode and the execute/writeback datapath. It holds an in-flight destination scoreboard and drives operand-bypass selects, issue stall, squash and writeback enables.

## Interface
Parameters:
- REG_AW, 5: register index width; index 0 is hard-wired zero.
- DEPTH, 3: stages after issue; S1 = execute, S_DEPTH = writeback; legal 2..8.
- LOAD_STAGE, 2: first stage holding load data; legal 2..DEPTH.
- FLUSH_DEPTH, 2: younger instructions squashed per taken branch, including the one at issue; legal 1..4.

Ports (SW = clog2(DEPTH+1)):
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2  in  REG_AW  source indices.
- issue_rs1_used, issue_rs2_used  in  1  source actually read.
- issue_rd  in  REG_AW  destination.
- issue_rd_we  in  1  instruction writes rd.
- issue_is_load  in  1  result comes from memory.
- branch_taken  in  1  branch/jump in S1 redirects the PC this cycle.
- issue_ready  out  1  combinational; 0 = hold fetch/decode.
- issue_kill  out  1  combinational; instruction at issue is squashed.
- s1_valid  out  1  registered; S1 holds a live instruction; mem write/read enables are gated with it.
- fwd_sel1, fwd_sel2  out  SW  registered; bypass source for S1 operands; 0 = register file, k = stage S_k result.
- wb_we  out  1  registered; register-file write enable.
- wb_rd  out  REG_AW  registered; writeback index.

## Operation
- Scoreboard: DEPTH entries {valid, rd, we, load}, shifting one stage per cycle. Entry k describes the instruction in S_k.
- Accepted issue: issue_valid & issue_ready & ~issue_kill. The accepted issue enters S1. Otherwise S1 receives a bubble (valid=0, we=0).
- Hazard check at issue against entries k = 1..DEPTH-1 with valid & we & rd != 0 & rd == rs & rs_used.
  - The S_DEPTH producer retires this cycle through the write-first register file and is not matched.
  - The youngest match (smallest k) wins.
- Load-use: if the youngest match is a load and k+1 < LOAD_STAGE, then issue_ready = 0. A bubble goes to S1 and decode holds.
- Forward select, registered into S1 with the instruction:
  - fwd_sel = k+1 on a match.
  - fwd_sel = 0 with no match, rs = 0, or rs unused.
  - ALU results are forwardable from S2.
- Squash counter sq_cnt, range 0..FLUSH_DEPTH-1:
  - branch_taken: issue_kill = 1 and sq_cnt <= FLUSH_DEPTH-1.
  - sq_cnt > 0: issue_kill = 1 and sq_cnt decrements.
  - Killed instructions enter S1 as bubbles, never stall, and issue_ready = 1.
- branch_taken with a simultaneous load-use stall: the branch wins. The stall is dropped and the instruction is killed.
- branch_taken while sq_cnt > 0: the counter reloads.
- Writeback: wb_we = entry S_DEPTH valid & we & rd != 0; wb_rd = its rd.

## Timing
- Reset: scoreboard cleared, sq_cnt = 0, s1_valid = 0, fwd_sel1/2 = 0, wb_we = 0, wb_rd = 0. issue_ready = 1 and issue_kill = 0 during and after reset.
- Reset mid-flush or mid-stall drops all in-flight state. The first cycle after rst falls accepts issue.
- An instruction accepted at cycle t:
  - has s1_valid and its fwd_sel at t+1;
  - has wb_we at t+DEPTH.
- Load-use stall length = LOAD_STAGE-1-k cycles, re-evaluated each cycle.
- Kill window after branch_taken at t: issue slots t..t+FLUSH_DEPTH-1.

## Structure
- Shared package core_pkg holds:
  - sb_entry_t {valid, rd, we, load};
  - FWD_RF = 0 constant;
  - the parameter legality checks (elaboration-time assertion).
- One sub-module, hazard_match: a combinational youngest-match search per source, instantiated twice. It returns the hit, the stage and the load flag.

## Test plan
- DEPTH=3, LOAD_STAGE=2: ALU writes x5 at t, consumer reads x5 at t+1 -> no stall, fwd_sel1=2 at t+2; consumer at t+2 -> fwd_sel1=3.
- DEPTH=3, LOAD_STAGE=3: load x7 at t, consumer rs2=x7 at t+1 -> issue_ready=0 for 1 cycle; issued t+2 with fwd_sel2=3; one bubble (s1_valid=0 at t+2).
- Writer to x0 and a consumer of x0 -> no stall, fwd_sel=0, wb_we=0.
- FLUSH_DEPTH=2: branch_taken at t -> issue_kill at t and t+1, s1_valid=0 at t+1 and t+2, no wb_we for killed slots; back-to-back branch_taken at t+1 -> kill extends to t+2.
- Load-use stall pending while branch_taken asserts -> issue_ready=1, issue_kill=1, no stall.
- rst asserted during a stall with 3 live entries -> all outputs at reset values next cycle, wb_we never asserted for flushed entries.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the integer-core hazard logic:
//               scoreboard entry layout, forward-select encoding and the
//               parameter legality check used at elaboration.
// Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    // Scoreboard rd field is sized for the widest supported register index;
    // narrower cores zero-extend into it.
    localparam int c_sb_rd_w = 8;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic [c_sb_rd_w-1:0] rd;
        logic                 we;
        logic                 load;
    } sb_entry_t;

    // True when the hazard controller parameter set is supported.
    function automatic bit hazard_params_ok(
        input int reg_aw,
        input int depth,
        input int load_stage,
        input int flush_depth
    );
        return (reg_aw >= 1) && (reg_aw <= c_sb_rd_w) &&
               (depth >= 2) && (depth <= 8) &&
               (load_stage >= 2) && (load_stage <= depth) &&
               (flush_depth >= 1) && (flush_depth <= 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Combinational youngest-producer search for one source operand
//               over the in-flight scoreboard entries S1..S(DEPTH-1).
// Revision    : 1.0  initial release
// ============================================================================
module hazard_match
    import core_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SW     = 2
) (
    input  sb_entry_t [DEPTH-1:1] sb,
    input  logic [REG_AW-1:0]     rs,
    input  logic                  rs_used,
    output logic                  hit,
    output logic [SW-1:0]         stage,
    output logic                  is_load
);

    // Walk from oldest to youngest so the youngest matching producer is the
    // last one written and therefore wins.
    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (rs_used && (rs != '0) && sb[k].valid && sb[k].we &&
                (sb[k].rd == c_sb_rd_w'(rs))) begin
                hit     = 1'b1;
                stage   = SW'(k);
                is_load = sb[k].load;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Tracks in-flight destinations,
//               generates operand bypass selects, load-use stalls, branch
//               squash and register-file writeback enables.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_STAGE  = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [REG_AW-1:0]            issue_rs1,
    input  logic [REG_AW-1:0]            issue_rs2,
    input  logic                         issue_rs1_used,
    input  logic                         issue_rs2_used,
    input  logic [REG_AW-1:0]            issue_rd,
    input  logic                         issue_rd_we,
    input  logic                         issue_is_load,
    input  logic                         branch_taken,
    output logic                         issue_ready,
    output logic                         issue_kill,
    output logic                         s1_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel2,
    output logic                         wb_we,
    output logic [REG_AW-1:0]            wb_rd
);

    localparam int c_sw   = $clog2(DEPTH + 1);
    localparam int c_sq_w = 2;
    // A load producer matched at stage k stalls while k < LOAD_STAGE-1.
    localparam logic [c_sw-1:0] c_lu_limit = c_sw'(LOAD_STAGE - 1);

    if (!hazard_params_ok(REG_AW, DEPTH, LOAD_STAGE, FLUSH_DEPTH)) begin : g_param_check
        $error("hazard_ctrl: illegal parameter combination");
    end

    // Entries S1..S(DEPTH-1); the S_DEPTH entry lives in the writeback registers.
    sb_entry_t [DEPTH-1:1] r_sb;
    logic [c_sw-1:0]       r_fwd1;
    logic [c_sw-1:0]       r_fwd2;
    logic                  r_wb_we;
    logic [REG_AW-1:0]     r_wb_rd;
    logic [c_sq_w-1:0]     r_sq_cnt;

    logic                  w_hit1;
    logic                  w_hit2;
    logic                  w_ld1;
    logic                  w_ld2;
    logic [c_sw-1:0]       w_stage1;
    logic [c_sw-1:0]       w_stage2;
    logic                  w_kill;
    logic                  w_lu_stall;
    logic                  w_accept;
    sb_entry_t             w_new;

    hazard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SW     (c_sw)
    ) u_match_rs1 (
        .sb      (r_sb),
        .rs      (issue_rs1),
        .rs_used (issue_rs1_used),
        .hit     (w_hit1),
        .stage   (w_stage1),
        .is_load (w_ld1)
    );

    hazard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SW     (c_sw)
    ) u_match_rs2 (
        .sb      (r_sb),
        .rs      (issue_rs2),
        .rs_used (issue_rs2_used),
        .hit     (w_hit2),
        .stage   (w_stage2),
        .is_load (w_ld2)
    );

    // Kill takes priority over a load-use stall; reset forces ready and no kill.
    always_comb begin
        w_kill     = ~rst & (branch_taken | (r_sq_cnt != '0));
        w_lu_stall = ~rst & issue_valid & ~w_kill &
                     ((w_hit1 & w_ld1 & (w_stage1 < c_lu_limit)) |
                      (w_hit2 & w_ld2 & (w_stage2 < c_lu_limit)));
        w_accept   = issue_valid & ~w_lu_stall & ~w_kill;
        w_new      = '0;
        if (w_accept) begin
            w_new.valid = 1'b1;
            w_new.rd    = c_sb_rd_w'(issue_rd);
            w_new.we    = issue_rd_we;
            w_new.load  = issue_is_load;
        end
    end

    assign issue_ready = ~w_lu_stall;
    assign issue_kill  = w_kill;

    // Scoreboard shift, bypass selects and writeback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb    <= '0;
            r_fwd1  <= c_sw'(FWD_RF);
            r_fwd2  <= c_sw'(FWD_RF);
            r_wb_we <= 1'b0;
            r_wb_rd <= '0;
        end else begin
            r_sb[1] <= w_new;
            for (int k = 2; k <= DEPTH - 1; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            // Producer seen at stage k sits one stage further on when the
            // consumer reaches S1.
            r_fwd1  <= (w_accept && w_hit1) ? (w_stage1 + c_sw'(1)) : c_sw'(FWD_RF);
            r_fwd2  <= (w_accept && w_hit2) ? (w_stage2 + c_sw'(1)) : c_sw'(FWD_RF);
            r_wb_we <= r_sb[DEPTH-1].valid & r_sb[DEPTH-1].we & (r_sb[DEPTH-1].rd != '0);
            r_wb_rd <= r_sb[DEPTH-1].rd[REG_AW-1:0];
        end
    end

    // Squash counter: a taken branch (re)loads it, otherwise it drains to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq_cnt <= '0;
        end else if (branch_taken) begin
            r_sq_cnt <= c_sq_w'(FLUSH_DEPTH - 1);
        end else if (r_sq_cnt != '0) begin
            r_sq_cnt <= r_sq_cnt - c_sq_w'(1);
        end
    end

    assign s1_valid = r_sb[1].valid;
    assign fwd_sel1 = r_fwd1;
    assign fwd_sel2 = r_fwd2;
    assign wb_we    = r_wb_we;
    assign wb_rd    = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (DEPTH=3,
//               LOAD_STAGE=3, FLUSH_DEPTH=2) with S1 and writeback scoreboards.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int DEPTH       = 3;
    localparam int LOAD_STAGE  = 3;
    localparam int FLUSH_DEPTH = 2;
    localparam int SW          = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs1;
    logic [REG_AW-1:0] issue_rs2;
    logic              issue_rs1_used;
    logic              issue_rs2_used;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_rd_we;
    logic              issue_is_load;
    logic              branch_taken;
    logic              issue_ready;
    logic              issue_kill;
    logic              s1_valid;
    logic [SW-1:0]     fwd_sel1;
    logic [SW-1:0]     fwd_sel2;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW      (REG_AW),
        .DEPTH       (DEPTH),
        .LOAD_STAGE  (LOAD_STAGE),
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_we    (issue_rd_we),
        .issue_is_load  (issue_is_load),
        .branch_taken   (branch_taken),
        .issue_ready    (issue_ready),
        .issue_kill     (issue_kill),
        .s1_valid       (s1_valid),
        .fwd_sel1       (fwd_sel1),
        .fwd_sel2       (fwd_sel2),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd)
    );

    typedef struct {
        logic          valid;
        logic [SW-1:0] f1;
        logic [SW-1:0] f2;
    } s1_exp_t;

    typedef struct {
        logic [REG_AW-1:0] rd;
        int                due;
    } wb_exp_t;

    s1_exp_t s1_q[$];
    wb_exp_t wb_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;

    // One issue cycle: drive, check combinational outputs mid-cycle, push the
    // expected S1/writeback results, then check what the DUT produced.
    task automatic step(
        input logic              r,
        input logic              v,
        input logic [REG_AW-1:0] rs1,
        input logic [REG_AW-1:0] rs2,
        input logic              u1,
        input logic              u2,
        input logic [REG_AW-1:0] rd,
        input logic              we,
        input logic              ld,
        input logic              br,
        input logic              e_rdy,
        input logic              e_kill,
        input logic [SW-1:0]     e_f1,
        input logic [SW-1:0]     e_f2,
        input string             tag
    );
        s1_exp_t se;
        wb_exp_t wx;
        logic    acc;
        rst            = r;
        issue_valid    = v;
        issue_rs1      = rs1;
        issue_rs2      = rs2;
        issue_rs1_used = u1;
        issue_rs2_used = u2;
        issue_rd       = rd;
        issue_rd_we    = we;
        issue_is_load  = ld;
        branch_taken   = br;
        @(negedge clk);
        checks++;
        assert (issue_ready === e_rdy) else begin
            errors++;
            $error("FAIL %s issue_ready got=%0b exp=%0b", tag, issue_ready, e_rdy);
        end
        checks++;
        assert (issue_kill === e_kill) else begin
            errors++;
            $error("FAIL %s issue_kill got=%0b exp=%0b", tag, issue_kill, e_kill);
        end
        acc      = v & e_rdy & ~e_kill & ~r;
        se.valid = acc;
        se.f1    = acc ? e_f1 : '0;
        se.f2    = acc ? e_f2 : '0;
        s1_q.push_back(se);
        if (r) wb_q.delete();
        if (acc && we && (rd != '0)) begin
            wx.rd  = rd;
            wx.due = cyc + DEPTH;
            wb_q.push_back(wx);
        end
        @(posedge clk);
        cyc++;
        #1;
        se = s1_q.pop_front();
        checks++;
        assert (s1_valid === se.valid) else begin
            errors++;
            $error("FAIL %s s1_valid got=%0b exp=%0b", tag, s1_valid, se.valid);
        end
        checks++;
        assert (fwd_sel1 === se.f1) else begin
            errors++;
            $error("FAIL %s fwd_sel1 got=%0d exp=%0d", tag, fwd_sel1, se.f1);
        end
        checks++;
        assert (fwd_sel2 === se.f2) else begin
            errors++;
            $error("FAIL %s fwd_sel2 got=%0d exp=%0d", tag, fwd_sel2, se.f2);
        end
        if (r) begin
            checks++;
            assert (wb_we === 1'b0 && wb_rd === '0) else begin
                errors++;
                $error("FAIL %s reset_wb got we=%0b rd=%0d exp we=0 rd=0", tag, wb_we, wb_rd);
            end
        end
        checks++;
        if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
            wx = wb_q.pop_front();
            assert (wb_we === 1'b1 && wb_rd === wx.rd) else begin
                errors++;
                $error("FAIL %s wb got we=%0b rd=%0d exp we=1 rd=%0d", tag, wb_we, wb_rd, wx.rd);
            end
        end else begin
            assert (wb_we === 1'b0) else begin
                errors++;
                $error("FAIL %s wb_idle got we=%0b rd=%0d exp we=0", tag, wb_we, wb_rd);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        issue_valid    = 1'b0;
        issue_rs1      = '0;
        issue_rs2      = '0;
        issue_rs1_used = 1'b0;
        issue_rs2_used = 1'b0;
        issue_rd       = '0;
        issue_rd_we    = 1'b0;
        issue_is_load  = 1'b0;
        branch_taken   = 1'b0;
        @(posedge clk);
        #1;
        //    r  v  rs1 rs2 u1 u2 rd  we ld br rdy kill f1 f2
        step(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, "rst0");
        step(1, 1,  5,  5, 1, 1,  5, 1, 0, 1, 1, 0, 0, 0, "rst_br");
        // ALU forwarding from S2 and S3, writer to x0, consumer of x0
        step(0, 1,  0,  0, 0, 0,  5, 1, 0, 0, 1, 0, 0, 0, "alu_x5");
        step(0, 1,  5,  0, 1, 0,  6, 1, 0, 0, 1, 0, 2, 0, "fwd_s2");
        step(0, 1,  5,  6, 1, 1,  0, 1, 0, 0, 1, 0, 3, 2, "fwd_s3_wr_x0");
        step(0, 1,  0,  0, 1, 1,  7, 1, 1, 0, 1, 0, 0, 0, "rd_x0_ld_x7");
        // Load-use: one stall cycle, then issue with forward from S3
        step(0, 1,  0,  7, 0, 1,  8, 1, 0, 0, 0, 0, 0, 0, "lu_stall");
        step(0, 1,  0,  7, 0, 1,  8, 1, 0, 0, 1, 0, 0, 3, "lu_issue");
        // Youngest match wins, unused source ignored, S_DEPTH not matched
        step(0, 1,  0,  0, 0, 0,  9, 1, 0, 0, 1, 0, 0, 0, "wr_x9_a");
        step(0, 1,  0,  0, 0, 0,  9, 1, 0, 0, 1, 0, 0, 0, "wr_x9_b");
        step(0, 1,  9,  9, 1, 0,  0, 0, 0, 0, 1, 0, 2, 0, "youngest");
        step(0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, "nop");
        step(0, 1,  9,  0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, "sdepth_nomatch");
        // Branch squash window, then back-to-back branches
        step(0, 1,  0,  0, 0, 0, 10, 1, 0, 0, 1, 0, 0, 0, "wr_x10");
        step(0, 1,  0,  0, 0, 0, 11, 1, 0, 1, 1, 1, 0, 0, "br_kill0");
        step(0, 1,  0,  0, 0, 0, 12, 1, 0, 0, 1, 1, 0, 0, "br_kill1");
        step(0, 1,  0,  0, 0, 0, 13, 1, 0, 0, 1, 0, 0, 0, "post_br");
        step(0, 1,  0,  0, 0, 0, 14, 1, 0, 1, 1, 1, 0, 0, "br2_a");
        step(0, 1,  0,  0, 0, 0, 14, 1, 0, 1, 1, 1, 0, 0, "br2_b");
        step(0, 1,  0,  0, 0, 0, 14, 1, 0, 0, 1, 1, 0, 0, "br2_tail");
        step(0, 1,  0,  0, 0, 0, 15, 1, 0, 0, 1, 0, 0, 0, "post_br2");
        // Branch beats a pending load-use stall
        step(0, 1,  0,  0, 0, 0, 16, 1, 1, 0, 1, 0, 0, 0, "ld_x16");
        step(0, 1, 16,  0, 1, 0, 17, 1, 0, 1, 1, 1, 0, 0, "br_vs_stall");
        step(0, 1, 16,  0, 1, 0, 17, 1, 0, 0, 1, 1, 0, 0, "br_vs_stall_tail");
        step(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, "idle");
        // Reset with three live entries while a load-use stall is pending
        step(0, 1,  0,  0, 0, 0, 20, 1, 0, 0, 1, 0, 0, 0, "wr_x20");
        step(0, 1,  0,  0, 0, 0, 22, 1, 0, 0, 1, 0, 0, 0, "wr_x22");
        step(0, 1,  0,  0, 0, 0, 21, 1, 1, 0, 1, 0, 0, 0, "ld_x21");
        step(1, 1, 21,  0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, "rst_in_stall");
        step(0, 1, 21,  0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, "post_rst_issue");
        // Reset in the middle of a squash window
        step(0, 1,  0,  0, 0, 0,  0, 0, 0, 1, 1, 1, 0, 0, "br_before_rst");
        step(1, 1,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, "rst_mid_flush");
        step(0, 1,  0,  0, 0, 0, 25, 1, 0, 0, 1, 0, 0, 0, "post_rst_wr");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "drain");
        end
        checks++;
        assert (wb_q.size() == 0) else begin
            errors++;
            $error("FAIL wb_drain pending got=%0d exp=0", wb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
